// File: rtl/hxd32_pkg.sv
// Shared hxd32 types: register address and the writeback entry carried by the slow path.
package hxd32_pkg;

   localparam int XLEN = 32;

   typedef logic [4:0] regaddr_t;

   typedef struct packed {
      regaddr_t            rd;
      logic [XLEN-1:0]     data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries; pointers wrap naturally because DEPTH is a power of two.
module wb_fifo
   import hxd32_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  wb_entry_t        din_i,
   input  logic             pop_i,
   output wb_entry_t        dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   wb_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Storage carries no reset; validity is tracked by the count alone.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         r_mem[r_wr_ptr] <= din_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push_i) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (pop_i) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (push_i && !pop_i) begin
            r_count <= r_count + 1'b1;
         end else if (pop_i && !push_i) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign dout_o  = r_mem[r_rd_ptr];
   assign full_o  = (r_count == CNT_W'(DEPTH));
   assign empty_o = (r_count == '0);
   assign count_o = r_count;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU and buffered multi-cycle results onto the regfile write port
// and tracks registers with outstanding multi-cycle writes.
module wb_arbiter
   import hxd32_pkg::*;
#(
   parameter int XLEN         = hxd32_pkg::XLEN,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            alu_valid_i,
   output logic            alu_ready_o,
   input  logic [4:0]      alu_rd_i,
   input  logic [XLEN-1:0] alu_data_i,
   input  logic            slow_valid_i,
   output logic            slow_ready_o,
   input  logic [4:0]      slow_rd_i,
   input  logic [XLEN-1:0] slow_data_i,
   input  logic            issue_en_i,
   input  logic [4:0]      issue_rd_i,
   output logic [31:0]     busy_o,
   output logic            rd_wr_en_o,
   output logic [4:0]      rd_wr_addr_o,
   output logic [XLEN-1:0] rd_wr_data_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   wb_entry_t        w_slow_in;
   wb_entry_t        w_head;
   logic             w_push;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W-1:0] w_count;
   logic             w_slow_win;
   logic             w_alu_win;
   regaddr_t         w_win_rd;
   logic [XLEN-1:0]  w_win_data;
   logic [31:0]      w_busy_set;
   logic [31:0]      w_busy_clr;

   logic [3:0]       r_starve;
   logic [31:0]      r_busy;
   logic             r_wr_en;
   regaddr_t         r_wr_addr;
   logic [XLEN-1:0]  r_wr_data;

   assign w_slow_in.rd   = slow_rd_i;
   assign w_slow_in.data = slow_data_i;
   assign slow_ready_o   = (w_count < CNT_W'(FIFO_DEPTH));
   assign w_push         = slow_valid_i && slow_ready_o;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push),
      .din_i   (w_slow_in),
      .pop_i   (w_slow_win),
      .dout_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (w_count)
   );

   // A full FIFO or an aged head forces the slow path through so it cannot back up the pipeline.
   assign w_slow_win  = !w_empty &&
                        (!alu_valid_i || w_full || (r_starve >= 4'(STARVE_LIMIT)));
   assign w_alu_win   = alu_valid_i && !w_slow_win;
   assign alu_ready_o = !w_slow_win;

   always_comb begin
      w_win_rd   = alu_rd_i;
      w_win_data = alu_data_i;
      if (w_slow_win) begin
         w_win_rd   = w_head.rd;
         w_win_data = w_head.data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_starve <= '0;
      end else if (w_empty || w_slow_win) begin
         r_starve <= '0;
      end else if (w_alu_win && (r_starve < 4'(STARVE_LIMIT))) begin
         r_starve <= r_starve + 1'b1;
      end
   end

   // Writes to x0 still complete the handshake but never reach the regfile.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else if (w_slow_win || w_alu_win) begin
         r_wr_en   <= (w_win_rd != 5'd0);
         r_wr_addr <= w_win_rd;
         r_wr_data <= w_win_data;
      end else begin
         r_wr_en   <= 1'b0;
      end
   end

   // Set is applied after clear so a newly issued op to the same register stays pending.
   always_comb begin
      w_busy_set = '0;
      w_busy_clr = '0;
      if (issue_en_i) begin
         w_busy_set = 32'd1 << issue_rd_i;
      end
      if (w_slow_win) begin
         w_busy_clr = 32'd1 << w_head.rd;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_busy <= '0;
      end else begin
         r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & 32'hFFFF_FFFE;
      end
   end

   assign busy_o       = r_busy;
   assign rd_wr_en_o   = r_wr_en;
   assign rd_wr_addr_o = r_wr_addr;
   assign rd_wr_data_o = r_wr_data;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the hxd32 register file.
- Merges two result sources into the regfile's single write port (rd_wr_en/rd_wr_addr/rd_wr_data):
  - the single-cycle ALU path;
  - the multi-cycle path (load/store unit, divider) through a small skid FIFO.
- Keeps a per-register busy scoreboard for outstanding multi-cycle results, used by the hazard unit to stall dependent instructions.

Parameters:
- XLEN, 32, data width of results and regfile.
- FIFO_DEPTH, 2, slow-path buffer entries; power of two, >= 2.
- STARVE_LIMIT, 4, max consecutive cycles a non-empty FIFO head may lose arbitration; 1..15.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- alu_valid_i  in  1  ALU result valid
- alu_ready_o  out  1  ALU result accepted this cycle
- alu_rd_i  in  5  ALU destination register
- alu_data_i  in  XLEN  ALU result
- slow_valid_i  in  1  multi-cycle result valid
- slow_ready_o  out  1  FIFO has space
- slow_rd_i  in  5  multi-cycle destination register
- slow_data_i  in  XLEN  multi-cycle result
- issue_en_i  in  1  multi-cycle op issued from decode
- issue_rd_i  in  5  destination of the issued op
- busy_o  out  32  scoreboard; bit n set = xn has a pending multi-cycle write
- rd_wr_en_o  out  1  to regfile rd_wr_en_i
- rd_wr_addr_o  out  5  to regfile rd_wr_addr_i
- rd_wr_data_o  out  XLEN  to regfile rd_wr_data_i

Behaviour:
Clock and reset:
- One clock: clk_i. Reset rst_i is synchronous and active-high.
- While rst_i is high at a rising edge, the following all clear to 0: rd_wr_en_o, rd_wr_addr_o, rd_wr_data_o, busy_o, FIFO pointers/count, starvation counter.
- Reset mid-operation discards FIFO contents and pending busy bits; no write is issued in the cycle after reset.

Slow-path FIFO:
- slow_ready_o = (count < FIFO_DEPTH). Combinational from registered count; does not depend on slow_valid_i.
- Push when slow_valid_i && slow_ready_o.
- Pop when the head wins arbitration.
- Simultaneous push and pop when full is not allowed: ready is already low.
- Simultaneous push and pop when not full: count is unchanged; pointers wrap modulo FIFO_DEPTH.
- No bypass: an entry pushed in cycle N can win arbitration in cycle N+1 at the earliest.

Arbitration (per cycle, combinational):
- slow_win = fifo_nonempty && (!alu_valid_i || fifo_full || starve_cnt >= STARVE_LIMIT).
- alu_ready_o = !slow_win.
- The ALU wins when alu_valid_i && !slow_win.

Starvation counter:
- Increments when FIFO is non-empty and the ALU wins.
- Resets to 0 on a slow win or when the FIFO is empty.
- Saturates at STARVE_LIMIT.

Write port:
- Registered, latency 1: the winner in cycle N drives rd_wr_en_o, rd_wr_addr_o, rd_wr_data_o in cycle N+1.
- A winner with rd = 0 is consumed (handshake completes, FIFO pops) but rd_wr_en_o stays 0.
- When there is no winner, rd_wr_en_o = 0 and addr/data hold their last values.

Scoreboard:
- issue_en_i with issue_rd_i != 0 sets busy[issue_rd_i] at the next edge.
- A slow win clears busy[head.rd] at the same edge that the write is registered.
- Set and clear of the same register in the same cycle: set wins (a newer op is outstanding).
- busy[0] is always 0.
- ALU writes never touch the scoreboard.

Decomposition:
- Shared package hxd32_pkg: XLEN, the regaddr_t (logic [4:0]) typedef, and the wb_entry_t struct {rd, data}.
- Sub-module wb_fifo: parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty/count.
- Arbitration, starvation counter, scoreboard and output register stay in wb_arbiter.

Test Plan:
1. Reset then ALU only: alu_valid_i=1, rd=5, data=0x15 → next cycle rd_wr_en_o=1, addr=5, data=0x0000_0015; alu_ready_o=1 throughout.
2. Slow only: issue rd=7 → busy_o=0x80; one cycle later push rd=7, data=0xDEAD_BEEF → write appears 2 cycles after the push; busy_o returns to 0 the same cycle rd_wr_en_o rises.
3. Contention: FIFO holds 1 entry, ALU valid every cycle → ALU wins 4 cycles; the 5th cycle the slow entry wins and alu_ready_o=0 for exactly that cycle.
4. Full FIFO: push 2 entries while ALU is continuously valid → slow_ready_o=0, slow wins immediately, alu_ready_o=0 until count < 2.
5. x0 and set/clear collision:
   - ALU write to rd=0 → rd_wr_en_o stays 0.
   - Issue rd=9 in the same cycle an older rd=9 slow result wins → busy[9] remains 1.
6. Reset mid-stream: 2 entries queued and busy_o=0x0000_0300, assert rst_i one cycle → busy_o=0, slow_ready_o=1, no rd_wr_en_o pulse afterwards.
